// File: rtl/host_word_entry_if.sv
// Bus between the receive path / game stage and host_word_entry.
// Handshake: rx_valid is a one-cycle strobe qualifying rx_data; there is no
// back-pressure, so a byte the block cannot use is dropped (err pulse).
// confirm and gameEnd are single-cycle requests sampled on the clock edge.
// game_rdy is a level: a guess is only forwarded while it is high.
// All outputs are registered and respond the cycle after the input.
interface host_word_entry_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        confirm;
  logic        game_rdy;
  logic        gameEnd;
  logic [39:0] setWord;
  logic        toggle_state;
  logic [7:0]  guess;
  logic [2:0]  letter_count;
  logic        word_locked;
  logic        dup;
  logic        err;
  logic [1:0]  dbg_state;

  modport master (
    output rx_data, rx_valid, confirm, game_rdy, gameEnd,
    input  setWord, toggle_state, guess, letter_count, word_locked, dup, err,
           dbg_state
  );

  modport slave (
    input  rx_data, rx_valid, confirm, game_rdy, gameEnd,
    output setWord, toggle_state, guess, letter_count, word_locked, dup, err,
           dbg_state
  );
endinterface

// File: rtl/host_word_entry.sv
// Host word entry: collects the secret word, arms the game stage, then turns
// player bytes into a held guess that only changes to never-sent letters.
module host_word_entry #(
  parameter int         WORD_LEN   = 5,
  parameter logic [7:0] ENTER_CODE = 8'h0D,
  parameter logic [7:0] BS_CODE    = 8'h08
) (
  input  logic               clk,
  input  logic               nRst,
  host_word_entry_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_ENTRY = 2'd0,
    ST_ARM   = 2'd1,
    ST_PLAY  = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  localparam logic [2:0] FULL_COUNT = 3'(WORD_LEN);

  state_t      state, state_n;
  logic [39:0] word_q, word_n;
  logic [2:0]  count_q, count_n;
  logic [7:0]  guess_q, guess_n;
  logic [25:0] used_q, used_n;
  logic        err_q, err_n;
  logic        dup_q, dup_n;
  logic        toggle_q;
  logic        locked_q;

  logic        is_letter;
  logic [7:0]  letter;
  logic [4:0]  idx;
  logic        full;

  // Classify the incoming byte and fold lowercase onto uppercase.
  always_comb begin
    is_letter = 1'b0;
    letter    = bus.rx_data;
    if (bus.rx_data >= 8'h41 && bus.rx_data <= 8'h5A) begin
      is_letter = 1'b1;
    end else if (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h7A) begin
      is_letter = 1'b1;
      letter    = bus.rx_data - 8'h20;
    end
  end

  // 'A'..'Z' have low five bits 1..26, so the mask index is that minus one.
  assign idx  = letter[4:0] - 5'd1;
  assign full = (count_q == FULL_COUNT);

  // State register.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= ST_ENTRY;
    else       state <= state_n;
  end

  // Next-state and datapath decisions; confirm beats rx, gameEnd beats rx.
  always_comb begin
    state_n = state;
    word_n  = word_q;
    count_n = count_q;
    guess_n = guess_q;
    used_n  = used_q;
    err_n   = 1'b0;
    dup_n   = 1'b0;
    case (state)
      ST_ENTRY: begin
        if (bus.confirm) begin
          if (full) state_n = ST_ARM;
          else      err_n   = 1'b1;
        end else if (bus.rx_valid) begin
          if (is_letter) begin
            if (!full) begin
              word_n  = {word_q[31:0], letter};
              count_n = count_q + 3'd1;
            end else begin
              err_n = 1'b1;
            end
          end else if (bus.rx_data == BS_CODE) begin
            if (count_q != 3'd0) begin
              word_n  = {8'h00, word_q[39:8]};
              count_n = count_q - 3'd1;
            end else begin
              err_n = 1'b1;
            end
          end else if (bus.rx_data == ENTER_CODE) begin
            if (full) state_n = ST_ARM;
            else      err_n   = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ST_ARM: begin
        state_n = bus.gameEnd ? ST_CLEAR : ST_PLAY;
      end
      ST_PLAY: begin
        if (bus.gameEnd) begin
          state_n = ST_CLEAR;
        end else if (bus.rx_valid) begin
          if (is_letter) begin
            if (used_q[idx]) begin
              dup_n = 1'b1;
            end else if (!bus.game_rdy) begin
              err_n = 1'b1;
            end else begin
              guess_n     = letter;
              used_n[idx] = 1'b1;
            end
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        word_n  = '0;
        count_n = '0;
        guess_n = '0;
        used_n  = '0;
        state_n = ST_ENTRY;
      end
      default: state_n = ST_ENTRY;
    endcase
  end

  // Datapath and registered status outputs.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      word_q   <= '0;
      count_q  <= '0;
      guess_q  <= '0;
      used_q   <= '0;
      err_q    <= 1'b0;
      dup_q    <= 1'b0;
      toggle_q <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      word_q   <= word_n;
      count_q  <= count_n;
      guess_q  <= guess_n;
      used_q   <= used_n;
      err_q    <= err_n;
      dup_q    <= dup_n;
      toggle_q <= (state_n == ST_ARM);
      locked_q <= (state_n == ST_ARM) || (state_n == ST_PLAY);
    end
  end

  assign bus.setWord      = word_q;
  assign bus.letter_count = count_q;
  assign bus.guess        = guess_q;
  assign bus.err          = err_q;
  assign bus.dup          = dup_q;
  assign bus.toggle_state = toggle_q;
  assign bus.word_locked  = locked_q;
  assign bus.dbg_state    = state;

endmodule
